mult_seq: RTL and testbench

MULT_SEQ -- requirements
Module: mult_seq

---
 rtl/mult_seq_if.sv | 23 ++
 rtl/mult_seq.sv | 109 ++++++++++
 tb/tb_mult_seq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mult_seq_if.sv
// Handshake and operand/result bundle for the sequential multiplier.
// The master drives the request and operands; the slave returns result and status.
interface mult_seq_if #(
  parameter int WIDTH = 12
);
  logic             Start;
  logic [WIDTH-1:0] Multiplicand;
  logic [WIDTH-1:0] Multiplier;
  logic [WIDTH-1:0] Res;
  logic             Overflow;
  logic             Busy;
  logic             Ready;

  modport master (
    output Start, Multiplicand, Multiplier,
    input  Res, Overflow, Busy, Ready
  );

  modport slave (
    input  Start, Multiplicand, Multiplier,
    output Res, Overflow, Busy, Ready
  );
endinterface

// File: rtl/mult_seq.sv
// Unsigned radix-2 shift-add multiplier, one multiplier bit per cycle,
// with the product saturated to WIDTH bits and an overflow flag.
module mult_seq #(
  parameter int WIDTH = 12
) (
  input  logic        clk,
  input  logic        reset,
  mult_seq_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q,  state_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0]   res_q,    res_d;
  logic               ovf_q,    ovf_d;
  logic [2*WIDTH-1:0] acc_next;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    acc_next = acc_q;

    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          mcand_d  = {{WIDTH{1'b0}}, bus.Multiplicand};
          mplier_d = bus.Multiplier;
          acc_d    = '0;
          cnt_d    = '0;
          // A zero operand needs no iterations, so the result is known now.
          if ((bus.Multiplicand == '0) || (bus.Multiplier == '0)) begin
            state_d = DONE;
            res_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          if (acc_next[2*WIDTH-1:WIDTH] != '0) begin
            res_d = '1;
            ovf_d = 1'b1;
          end else begin
            res_d = acc_next[WIDTH-1:0];
            ovf_d = 1'b0;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.Res      = res_q;
  assign bus.Overflow = ovf_q;
  assign bus.Busy     = (state_q == CALC);
  assign bus.Ready    = (state_q == DONE);

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed cases plus random operands,
// compared against a plain-arithmetic saturating product model.
module tb_mult_seq;

  localparam int W    = 12;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mult_seq_if #(.WIDTH(W)) bus ();

  mult_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int num_checks = 0;
  int num_pass   = 0;
  int last_res   = 0;
  int last_ovf   = 0;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    num_checks++;
    if (observed == expected) num_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // True product, then clamp to WIDTH bits.
  function automatic void refModel(input int a, input int b, output int res, output int ovf);
    longint p;
    p = longint'(a) * longint'(b);
    if (p > longint'(MAXV)) begin
      res = MAXV;
      ovf = 1;
    end else begin
      res = int'(p);
      ovf = 0;
    end
  endfunction

  // One complete operation from IDLE; checks latency, Busy span, result and hold.
  task automatic applyStimulus(input int a, input int b);
    int exp_res, exp_ovf, exp_lat, cycles, busy_cycles;
    refModel(a, b, exp_res, exp_ovf);
    exp_lat = (a == 0 || b == 0) ? 0 : W;
    bus.Start        = 1'b1;
    bus.Multiplicand = W'(a);
    bus.Multiplier   = W'(b);
    nextCycle();
    bus.Start        = 1'b0;
    bus.Multiplicand = W'($urandom);
    bus.Multiplier   = W'($urandom);
    cycles      = 0;
    busy_cycles = 0;
    while (!bus.Ready && cycles < 3 * W) begin
      if (cycles == 1) begin
        checkOutput("res_hold_calc", bus.Res, last_res);
        checkOutput("ovf_hold_calc", bus.Overflow, last_ovf);
      end
      if (bus.Busy) busy_cycles++;
      nextCycle();
      cycles++;
    end
    checkOutput("ready_seen", bus.Ready, 1);
    checkOutput("latency", cycles, exp_lat);
    checkOutput("busy_cycles", busy_cycles, exp_lat);
    checkOutput("busy_at_ready", bus.Busy, 0);
    checkOutput("res", bus.Res, exp_res);
    checkOutput("overflow", bus.Overflow, exp_ovf);
    last_res = exp_res;
    last_ovf = exp_ovf;
    nextCycle();
    checkOutput("ready_one_cycle", bus.Ready, 0);
    checkOutput("res_held", bus.Res, exp_res);
  endtask

  function automatic int pickOperand();
    case ($urandom_range(0, 7))
      0:       return 0;
      1:       return MAXV;
      2, 3, 4: return int'($urandom_range(1, 63));
      default: return int'($urandom_range(1, MAXV));
    endcase
  endfunction

  initial begin
    $display("[TB] watchdog armed");
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int ready_cnt, ready_res, rand_a, rand_b;
    int pulse_at[$];

    reset            = 1'b1;
    bus.Start        = 1'b0;
    bus.Multiplicand = '0;
    bus.Multiplier   = '0;
    repeat (3) nextCycle();
    checkOutput("rst_res", bus.Res, 0);
    checkOutput("rst_ovf", bus.Overflow, 0);
    checkOutput("rst_busy", bus.Busy, 0);
    checkOutput("rst_ready", bus.Ready, 0);

    // Reset wins over a simultaneous Start.
    bus.Start = 1'b1;
    bus.Multiplicand = W'(5);
    bus.Multiplier = W'(5);
    nextCycle();
    reset     = 1'b0;
    bus.Start = 1'b0;
    checkOutput("rst_prio_busy", bus.Busy, 0);
    checkOutput("rst_prio_ready", bus.Ready, 0);
    nextCycle();
    checkOutput("rst_prio_busy2", bus.Busy, 0);
    checkOutput("rst_prio_ready2", bus.Ready, 0);

    applyStimulus(3, 4);
    applyStimulus(63, 65);
    applyStimulus(64, 64);
    applyStimulus(4095, 4095);
    applyStimulus(0, 2262);
    applyStimulus(10, 0);
    applyStimulus(1, 4095);

    // A second Start during CALC must be dropped.
    bus.Start = 1'b1;
    bus.Multiplicand = W'(200);
    bus.Multiplier = W'(5);
    nextCycle();
    bus.Start = 1'b0;
    repeat (4) nextCycle();
    bus.Start = 1'b1;
    bus.Multiplicand = W'(7);
    bus.Multiplier = W'(7);
    nextCycle();
    bus.Start = 1'b0;
    bus.Multiplicand = W'(999);
    bus.Multiplier = W'(3);
    ready_cnt = 0;
    ready_res = -1;
    for (int i = 0; i < 30; i++) begin
      if (bus.Ready) begin
        ready_cnt++;
        ready_res = bus.Res;
      end
      nextCycle();
    end
    checkOutput("midcalc_ready_count", ready_cnt, 1);
    checkOutput("midcalc_res", ready_res, 1000);
    last_res = 1000;
    last_ovf = 0;

    // Reset in the middle of CALC aborts without a Ready pulse.
    bus.Start = 1'b1;
    bus.Multiplicand = W'(90);
    bus.Multiplier = W'(9);
    nextCycle();
    bus.Start = 1'b0;
    repeat (5) nextCycle();
    checkOutput("abort_busy_before", bus.Busy, 1);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    checkOutput("abort_res", bus.Res, 0);
    checkOutput("abort_ovf", bus.Overflow, 0);
    checkOutput("abort_busy", bus.Busy, 0);
    checkOutput("abort_ready", bus.Ready, 0);
    ready_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.Ready || bus.Busy) ready_cnt++;
      nextCycle();
    end
    checkOutput("abort_no_activity", ready_cnt, 0);
    last_res = 0;
    last_ovf = 0;
    applyStimulus(16, 3);

    // Start held high: one result every W+2 cycles.
    bus.Start = 1'b1;
    bus.Multiplicand = W'(255);
    bus.Multiplier = W'(5);
    for (int c = 1; c <= 60 && pulse_at.size() < 3; c++) begin
      nextCycle();
      if (bus.Ready) begin
        pulse_at.push_back(c);
        checkOutput("b2b_res", bus.Res, 1275);
        checkOutput("b2b_ovf", bus.Overflow, 0);
        if (pulse_at.size() == 3) bus.Start = 1'b0;
      end
    end
    bus.Start = 1'b0;
    checkOutput("b2b_pulses", pulse_at.size(), 3);
    if (pulse_at.size() == 3) begin
      checkOutput("b2b_first", pulse_at[0], W + 1);
      checkOutput("b2b_gap1", pulse_at[1] - pulse_at[0], W + 2);
      checkOutput("b2b_gap2", pulse_at[2] - pulse_at[1], W + 2);
    end
    nextCycle();
    nextCycle();
    checkOutput("b2b_stopped", bus.Busy, 0);
    last_res = 1275;
    last_ovf = 0;

    for (int n = 0; n < 20; n++) begin
      rand_a = pickOperand();
      rand_b = pickOperand();
      applyStimulus(rand_a, rand_b);
    end

    $display("%0d/%0d checks passed", num_pass, num_checks);
    $finish;
  end

endmodule
